// File: rtl/nw_pkg.sv
// Shared definitions for the traceback decoder: column opcodes, step directions, FSM states.
package nw_pkg;

    localparam logic [1:0] OP_MATCH    = 2'd0;
    localparam logic [1:0] OP_MISMATCH = 2'd1;
    localparam logic [1:0] OP_GAP_S2   = 2'd2;
    localparam logic [1:0] OP_GAP_S1   = 2'd3;

    // Step from the held cell to the next accepted cell
    localparam logic [1:0] CORNER_DIR = 2'd0;
    localparam logic [1:0] TOP_DIR    = 2'd1;
    localparam logic [1:0] LEFT_DIR   = 2'd2;
    localparam logic [1:0] BAD_DIR    = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        HOLD,
        EMIT,
        FINAL,
        DONE,
        ERR
    } nw_state_e;

endpackage

// File: rtl/nw_char_sel.sv
// Picks character idx out of a packed string; character 0 sits in the most significant slot.
module nw_char_sel #(
    parameter int LENGTH = 10,
    parameter int CWIDTH = 2,
    parameter int IWIDTH = 8
) (
    input  logic [LENGTH*CWIDTH-1:0] str,
    input  logic [IWIDTH-1:0]        idx,
    output logic [CWIDTH-1:0]        ch
);

    always_comb begin
        ch = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (int'(idx) == i) begin
                ch = str[(LENGTH-1-i)*CWIDTH +: CWIDTH];
            end
        end
    end

endmodule

// File: rtl/nw_trace_decoder.sv
// Turns a Needleman-Wunsch traceback coordinate stream into alignment columns with a running score.
// Optional per-opcode column counters are built when NW_DECODE_STATS_EN is defined.
//
// state | meaning
// IDLE  | after reset, waiting for start
// FIRST | expecting the (LENGTH-1,LENGTH-1) corner
// HOLD  | holding a cell, waiting for its successor
// EMIT  | column for the previously held cell on the output
// FINAL | closing (0,0) column on the output, out_last set
// DONE  | decode complete
// ERR   | malformed stream seen
module nw_trace_decoder
    import nw_pkg::*;
#(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int SWIDTH      = 16,
    parameter int CORD_LENGTH = 8,
    parameter int MATCH       = 1,
    parameter int INDEL       = -1,
    parameter int MISMATCH    = -1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [LENGTH*CWIDTH-1:0]    s1,
    input  logic [LENGTH*CWIDTH-1:0]    s2,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CORD_LENGTH-1:0]      in_x,
    input  logic [CORD_LENGTH-1:0]      in_y,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [1:0]                  out_op,
    output logic [CWIDTH-1:0]           out_c1,
    output logic [CWIDTH-1:0]           out_c2,
    output logic                        out_last,
    output logic                        done,
    output logic                        error,
    output logic signed [SWIDTH-1:0]    score,
    output logic [CORD_LENGTH:0]        n_match,
    output logic [CORD_LENGTH:0]        n_mismatch,
    output logic [CORD_LENGTH:0]        n_gap
);

    localparam int CW  = CORD_LENGTH;
    localparam int CW1 = CORD_LENGTH + 1;
    localparam logic [CW1-1:0] ONE  = CW1'(1);
    localparam logic [CW-1:0]  LAST = CW'(LENGTH - 1);

    nw_state_e state_q, state_d;

    logic [CW-1:0]              hx_q, hx_d, hy_q, hy_d;
    logic                       in_ready_q, in_ready_d;
    logic                       out_valid_q, out_valid_d;
    logic [1:0]                 out_op_q, out_op_d;
    logic [CWIDTH-1:0]          out_c1_q, out_c1_d, out_c2_q, out_c2_d;
    logic                       out_last_q, out_last_d;
    logic                       done_q, done_d, error_q, error_d;
    logic signed [SWIDTH-1:0]   score_q, score_d;

    logic               accept, out_fire, held_zero, first_ok, step_ok, in_range;
    logic [CW1-1:0]     nx1, ny1, hxw, hyw;
    logic [1:0]         step_dir, col_dir, col_op;
    logic [CWIDTH-1:0]  ch1, ch2, col_c1, col_c2;

    nw_char_sel #(.LENGTH(LENGTH), .CWIDTH(CWIDTH), .IWIDTH(CW)) u_sel_s1 (
        .str (s1),
        .idx (hy_q),
        .ch  (ch1)
    );

    nw_char_sel #(.LENGTH(LENGTH), .CWIDTH(CWIDTH), .IWIDTH(CW)) u_sel_s2 (
        .str (s2),
        .idx (hx_q),
        .ch  (ch2)
    );

    function automatic logic signed [SWIDTH-1:0] op_weight(input logic [1:0] op);
        case (op)
            OP_MATCH:    op_weight = SWIDTH'(MATCH);
            OP_MISMATCH: op_weight = SWIDTH'(MISMATCH);
            default:     op_weight = SWIDTH'(INDEL);
        endcase
    endfunction

    assign accept    = in_valid && in_ready_q;
    assign out_fire  = out_valid_q && out_ready;
    assign held_zero = (hx_q == '0) && (hy_q == '0);
    assign in_range  = (int'(in_x) < LENGTH) && (int'(in_y) < LENGTH);
    assign first_ok  = (in_x == LAST) && (in_y == LAST);

    assign nx1 = {1'b0, in_x} + ONE;
    assign ny1 = {1'b0, in_y} + ONE;
    assign hxw = {1'b0, hx_q};
    assign hyw = {1'b0, hy_q};

    always_comb begin
        step_dir = BAD_DIR;
        if (nx1 == hxw && ny1 == hyw)
            step_dir = CORNER_DIR;
        else if (in_x == hx_q && ny1 == hyw)
            step_dir = TOP_DIR;
        else if (nx1 == hxw && in_y == hy_q)
            step_dir = LEFT_DIR;
    end

    assign step_ok = in_range && (step_dir != BAD_DIR);
    // Outside a HOLD accept the only column ever loaded is the closing (0,0) diagonal
    assign col_dir = (state_q == HOLD && accept) ? step_dir : CORNER_DIR;

    always_comb begin
        col_op = (ch1 == ch2) ? OP_MATCH : OP_MISMATCH;
        col_c1 = ch1;
        col_c2 = ch2;
        case (col_dir)
            TOP_DIR: begin
                col_op = OP_GAP_S2;
                col_c2 = '0;
            end
            LEFT_DIR: begin
                col_op = OP_GAP_S1;
                col_c1 = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            hx_q        <= '0;
            hy_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_c1_q    <= '0;
            out_c2_q    <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            score_q     <= '0;
        end else begin
            state_q     <= state_d;
            hx_q        <= hx_d;
            hy_q        <= hy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_c1_q    <= out_c1_d;
            out_c2_q    <= out_c2_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            error_q     <= error_d;
            score_q     <= score_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = FIRST;
        end else begin
            case (state_q)
                FIRST: if (accept) state_d = first_ok ? HOLD : ERR;
                HOLD: begin
                    if (accept)
                        state_d = step_ok ? EMIT : ERR;
                    else if (held_zero)
                        state_d = FINAL;
                end
                EMIT:  if (out_fire) state_d = held_zero ? FINAL : HOLD;
                FINAL: if (out_fire) state_d = DONE;
                default: ;
            endcase
        end
    end

`ifdef NW_DECODE_STATS_EN
    logic [CW1-1:0] n_match_q, n_match_d, n_mismatch_q, n_mismatch_d, n_gap_q, n_gap_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            n_match_q    <= '0;
            n_mismatch_q <= '0;
            n_gap_q      <= '0;
        end else begin
            n_match_q    <= n_match_d;
            n_mismatch_q <= n_mismatch_d;
            n_gap_q      <= n_gap_d;
        end
    end

    always_comb begin
        n_match_d    = n_match_q;
        n_mismatch_d = n_mismatch_q;
        n_gap_d      = n_gap_q;
        if (start) begin
            n_match_d    = '0;
            n_mismatch_d = '0;
            n_gap_d      = '0;
        end else if (out_fire) begin
            case (out_op_q)
                OP_MATCH:    n_match_d    = n_match_q + ONE;
                OP_MISMATCH: n_mismatch_d = n_mismatch_q + ONE;
                default:     n_gap_d      = n_gap_q + ONE;
            endcase
        end
    end

    assign n_match    = n_match_q;
    assign n_mismatch = n_mismatch_q;
    assign n_gap      = n_gap_q;
`else
    assign n_match    = '0;
    assign n_mismatch = '0;
    assign n_gap      = '0;
`endif

    always_comb begin
        hx_d        = hx_q;
        hy_d        = hy_q;
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_c1_d    = out_c1_q;
        out_c2_d    = out_c2_q;
        out_last_d  = out_last_q;
        done_d      = done_q;
        error_d     = error_q;
        score_d     = score_q;
        if (start) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b0;
            error_d     = 1'b0;
            score_d     = '0;
        end else begin
            if (out_fire)
                score_d = score_q + op_weight(out_op_q);
            case (state_q)
                FIRST: begin
                    if (accept && first_ok) begin
                        hx_d = in_x;
                        hy_d = in_y;
                    end
                end
                HOLD: begin
                    if ((accept && step_ok) || (!accept && held_zero)) begin
                        out_valid_d = 1'b1;
                        out_op_d    = col_op;
                        out_c1_d    = col_c1;
                        out_c2_d    = col_c2;
                        out_last_d  = !accept;
                    end
                    if (accept && step_ok) begin
                        hx_d = in_x;
                        hy_d = in_y;
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        out_valid_d = held_zero;
                        out_op_d    = held_zero ? col_op : out_op_q;
                        out_c1_d    = held_zero ? col_c1 : out_c1_q;
                        out_c2_d    = held_zero ? col_c2 : out_c2_q;
                        out_last_d  = held_zero;
                    end
                end
                FINAL: begin
                    if (out_fire) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end
                end
                default: ;
            endcase
            if (state_d == ERR && state_q != ERR) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                done_d      = 1'b1;
                error_d     = 1'b1;
            end
        end
    end

    assign in_ready_d = (state_d == FIRST) ||
                        (state_d == HOLD && !(hx_d == '0 && hy_d == '0));

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_c1    = out_c1_q;
    assign out_c2    = out_c2_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign error     = error_q;
    assign score     = score_q;

endmodule

// File: tb/tb_nw_trace_decoder.sv
// Directed bench for nw_trace_decoder with LENGTH=4 and s1=s2=ACGT.
module tb_nw_trace_decoder;

    localparam int LENGTH = 4;
    localparam int CWIDTH = 2;
    localparam int SWIDTH = 16;
    localparam int CL     = 8;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic [LENGTH*CWIDTH-1:0] s1 = 8'b00_01_10_11;
    logic [LENGTH*CWIDTH-1:0] s2 = 8'b00_01_10_11;
    logic                     start = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [CL-1:0]            in_x = '0;
    logic [CL-1:0]            in_y = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [1:0]               out_op;
    logic [CWIDTH-1:0]        out_c1, out_c2;
    logic                     out_last, done, error;
    logic signed [SWIDTH-1:0] score;
    logic [CL:0]              n_match, n_mismatch, n_gap;

    int n_tot = 0;
    int n_bad = 0;
    logic [6:0] colq[$];

    nw_trace_decoder #(.LENGTH(LENGTH), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH), .CORD_LENGTH(CL)) dut (
        .clk(clk), .reset(reset), .s1(s1), .s2(s2), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_c1(out_c1), .out_c2(out_c2), .out_last(out_last),
        .done(done), .error(error), .score(score),
        .n_match(n_match), .n_mismatch(n_mismatch), .n_gap(n_gap)
    );

    always #5 clk = ~clk;

    // Column record: {last, op, c1, c2}
    always @(negedge clk)
        if (out_valid && out_ready) colq.push_back({out_last, out_op, out_c1, out_c2});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tot++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        colq.delete();
    endtask

    task automatic send(input int x, input int y);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_x = CL'(x);
        in_y = CL'(y);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 40) begin
                chk("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done, 1);
    endtask

    task automatic run_diag();
        send(3, 3); send(2, 2); send(1, 1); send(0, 0);
    endtask

    task automatic check_cols(input string tag, input logic [6:0] e[5], input int n);
        chk({tag, "_ncols"}, colq.size(), n);
        for (int i = 0; i < n && i < colq.size(); i++)
            chk($sformatf("%s_col%0d", tag, i), colq[i], e[i]);
    endtask

    logic [6:0] exp_diag[5] = '{7'b0_00_11_11, 7'b0_00_10_10, 7'b0_00_01_01, 7'b1_00_00_00, 7'b0};
    logic [6:0] exp_mix[5]  = '{7'b0_10_11_00, 7'b0_01_10_11, 7'b0_01_01_10, 7'b0_11_00_01, 7'b1_00_00_00};
    logic [6:0] snap;

    initial begin
        // reset held with start asserted: reset wins
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outs", {out_op, out_c1, out_c2, out_last}, 0);
        chk("rst_done_err", {done, error}, 0);
        chk("rst_score", 32'($signed(score)), 0);
        chk("rst_counts", {n_match, n_mismatch, n_gap}, 0);

        // in_valid ignored in IDLE
        @(posedge clk); #1;
        in_valid = 1'b1; in_x = 8'd3; in_y = 8'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_out_valid", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // all-diagonal decode
        pulse_start();
        chk("first_in_ready", in_ready, 1);
        run_diag();
        wait_done("diag_done");
        check_cols("diag", exp_diag, 4);
        chk("diag_score", 32'($signed(score)), 4);
        chk("diag_error", error, 0);
`ifdef NW_DECODE_STATS_EN
        chk("diag_n_match", n_match, 4);
`else
        chk("diag_n_match", n_match, 0);
`endif

        // mixed steps
        @(posedge clk); #1;
        pulse_start();
        send(3, 3); send(3, 2); send(2, 1); send(1, 0); send(0, 0);
        wait_done("mix_done");
        check_cols("mix", exp_mix, 5);
        chk("mix_score", 32'($signed(score)), -3);
`ifdef NW_DECODE_STATS_EN
        chk("mix_counts", {n_match, n_mismatch, n_gap}, {9'd1, 9'd2, 9'd2});
`else
        chk("mix_counts", {n_match, n_mismatch, n_gap}, 0);
`endif

        // back-pressure on the first column
        @(posedge clk); #1;
        pulse_start();
        out_ready = 1'b0;
        send(3, 3);
        @(negedge clk);
        chk("bp_ov_pre", out_valid, 0);
        @(posedge clk); #1;
        send(2, 2);
        @(negedge clk);
        chk("bp_ov_rise", out_valid, 1);
        snap = {out_last, out_op, out_c1, out_c2};
        chk("bp_first_col", snap, exp_diag[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_stable%0d", i), {out_valid, out_last, out_op, out_c1, out_c2}, {1'b1, snap});
            chk($sformatf("bp_in_ready%0d", i), in_ready, 0);
            chk($sformatf("bp_score%0d", i), 32'($signed(score)), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(1, 1); send(0, 0);
        wait_done("bp_done");
        check_cols("bp", exp_diag, 4);
        chk("bp_score", 32'($signed(score)), 4);

        // bad first coordinate, then recovery
        @(posedge clk); #1;
        pulse_start();
        send(2, 3);
        @(negedge clk);
        chk("e1_err_done", {error, done}, 2'b11);
        chk("e1_out_valid", out_valid, 0);
        chk("e1_in_ready", in_ready, 0);
        chk("e1_ncols", colq.size(), 0);
        @(posedge clk); #1;
        pulse_start();
        chk("e1_clear", {error, done}, 0);
        run_diag();
        wait_done("e1_rec_done");
        chk("e1_rec_score", 32'($signed(score)), 4);

        // illegal step
        @(posedge clk); #1;
        pulse_start();
        send(3, 3); send(1, 1);
        @(negedge clk);
        chk("e2_err_done", {error, done}, 2'b11);
        chk("e2_ready_valid", {in_ready, out_valid}, 0);

        // start mid-decode after two columns
        @(posedge clk); #1;
        pulse_start();
        send(3, 3); send(2, 2); send(1, 1);
        for (int i = 0; i < 40 && colq.size() < 2; i++) @(negedge clk);
        chk("mid_ncols", colq.size(), 2);
        @(posedge clk); #1;
        chk("mid_score", 32'($signed(score)), 2);
        pulse_start();
        chk("mid_clear_score", 32'($signed(score)), 0);
        chk("mid_clear_counts", {n_match, n_mismatch, n_gap}, 0);
        chk("mid_clear_flags", {done, error, out_valid, in_ready}, 4'b0001);
        run_diag();
        wait_done("mid_done");
        check_cols("mid", exp_diag, 4);
        chk("mid_score_final", 32'($signed(score)), 4);
`ifdef NW_DECODE_STATS_EN
        chk("mid_n_match", n_match, 4);
`else
        chk("mid_n_match", n_match, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
